rsa_batch_seq: RTL
==================

RSA_BATCH_SEQ -- requirements
Module: rsa_batch_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits matching the RSA unit.
REQ-002 SHALL have parameter DEPTH, default 4, number of message/result slots (power of two).
REQ-003 SHALL have parameter TIMEOUT, default 64, maximum RUN cycles per job before error.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rstb  input  1  asynchronous active-low reset.
REQ-006 SHALL have port ena  input  1  design enable; low freezes all state.
REQ-007 SHALL have port start  input  1  single-cycle pulse, begin batch.
REQ-008 SHALL have port abort  input  1  single-cycle pulse, cancel batch.
REQ-009 SHALL have port count  input  $clog2(DEPTH)+1  jobs in batch, sampled on accepted start.
REQ-010 SHALL have port m_wr_en  input  1  message slot write strobe.
REQ-011 SHALL have port m_wr_addr  input  $clog2(DEPTH)  message slot index.
REQ-012 SHALL have port m_wr_data  input  WIDTH  message value.
REQ-013 SHALL have port c_rd_addr  input  $clog2(DEPTH)  result slot index.
REQ-014 SHALL have port c_rd_data  output  WIDTH  result slot contents, combinational read.
REQ-015 SHALL have port rsa_m  output  WIDTH  message driven to RSA unit M.
REQ-016 SHALL have port rsa_clear  output  1  clear to RSA unit.
REQ-017 SHALL have port rsa_en  output  1  enable to RSA unit.
REQ-018 SHALL have port rsa_eoc  input  1  end-of-computation from RSA unit.
REQ-019 SHALL have port rsa_c  input  WIDTH  result from RSA unit.
REQ-020 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-021 SHALL have port irq  output  1  sticky batch-complete flag.
REQ-022 SHALL have port err  output  1  sticky timeout flag.
REQ-023 SHALL have port irq_clr  input  1  pulse, clears irq and err.

Function
REQ-024 SHALL implement FSM states IDLE, LOAD, CLEAR, RUN, STORE, DONE.
REQ-025 IDLE: start with count in 1..DEPTH SHALL latch count, set idx=0, go LOAD; count=0 SHALL go DONE with no RSA activity; count>DEPTH SHALL be saturated to DEPTH.
REQ-026 LOAD: rsa_m SHALL register m_mem[idx]; next CLEAR.
REQ-027 CLEAR: rsa_clear SHALL be high exactly this one cycle, rsa_en low; next RUN; RUN timer reset to 0.
REQ-028 RUN: rsa_en SHALL be high; timer increments each enabled cycle; rsa_eoc=1 SHALL write rsa_c to c_mem[idx] and go STORE.
REQ-029 RUN: timer reaching TIMEOUT-1 without eoc SHALL set err, pulse rsa_clear one cycle, go IDLE; irq not set.
REQ-030 STORE: rsa_en low; if idx==count-1 go DONE else idx+1, go LOAD.
REQ-031 DONE: SHALL set irq, go IDLE next cycle.
REQ-032 Per-job latency SHALL be 3 cycles + RUN cycles (LOAD, CLEAR, STORE); start to irq = sum of jobs + 2 cycles.
REQ-033 rsa_m SHALL hold its last loaded value outside LOAD.
REQ-034 abort in any non-IDLE state SHALL go IDLE next cycle, pulse rsa_clear one cycle, leave irq/err unchanged, leave completed c_mem slots intact.
REQ-035 abort and start in the same IDLE cycle: abort wins, start ignored.
REQ-036 start while busy SHALL be ignored.
REQ-037 rsa_eoc and timeout in the same cycle: eoc wins.
REQ-038 m_wr_en while busy SHALL be ignored; in IDLE it writes m_mem[m_wr_addr].
REQ-039 irq_clr coincident with a set event: set wins.
REQ-040 ena low: state, idx, timer, flags, memories SHALL hold; rsa_en and rsa_clear forced 0; inputs ignored.
REQ-041 rsa_eoc outside RUN SHALL be ignored.

Reset
REQ-042 rstb low SHALL asynchronously force IDLE, idx=0, timer=0, rsa_m=0, rsa_clear=0, rsa_en=0, busy=0, irq=0, err=0.
REQ-043 m_mem and c_mem SHALL reset to 0.
REQ-044 Reset mid-batch SHALL abandon the batch with no irq.

Verification (RSA stub: eoc 5 cycles after en rises, C = M xor 8'hA5)
REQ-045 Write M={8'h11,8'h22,8'h33,8'h44}, count=4, start -> c_mem={8'hB4,8'h87,8'h96,8'hE1}, irq at start+34, four rsa_clear pulses.
REQ-046 count=0, start -> irq set 2 cycles later, rsa_en/rsa_clear never high.
REQ-047 Stub never asserts eoc, count=1 -> err set after 64 RUN cycles, rsa_clear pulse, busy low, irq 0.
REQ-048 abort during job 2 of 3 -> IDLE next cycle, c_mem[0] valid, c_mem[1..2] unchanged, irq 0.
REQ-049 ena low for 10 cycles during RUN -> rsa_en 0, timer frozen, batch completes with correct results after ena high.
REQ-050 irq_clr same cycle as DONE -> irq remains 1; next irq_clr -> irq and err 0.

Source files
------------

// File: rtl/rsa_batch_seq_if.sv
// rsa_batch_seq_if: link between the batch sequencer (master) and the RSA unit (slave)
interface rsa_batch_seq_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] rsa_m;
  logic [WIDTH-1:0] rsa_c;
  logic rsa_clear;
  logic rsa_en;
  logic rsa_eoc;
  modport master (output rsa_m, rsa_clear, rsa_en, input rsa_eoc, rsa_c);
  modport slave (input rsa_m, rsa_clear, rsa_en, output rsa_eoc, rsa_c);
endinterface

// File: rtl/rsa_batch_seq.sv
// rsa_batch_seq: runs a batch of messages through an external RSA unit into a result buffer
module rsa_batch_seq #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rstb,
  input  logic ena,
  input  logic start,
  input  logic abort,
  input  logic [$clog2(DEPTH):0] count,
  input  logic m_wr_en,
  input  logic [$clog2(DEPTH)-1:0] m_wr_addr,
  input  logic [WIDTH-1:0] m_wr_data,
  input  logic [$clog2(DEPTH)-1:0] c_rd_addr,
  output logic [WIDTH-1:0] c_rd_data,
  rsa_batch_seq_if.master rsa,
  output logic busy,
  output logic irq,
  output logic err,
  input  logic irq_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CMAX = CW'(DEPTH);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] CLEAR = 3'd2;
  localparam logic [2:0] RUN = 3'd3;
  localparam logic [2:0] STORE = 3'd4;
  localparam logic [2:0] DONE = 3'd5;
  logic [2:0] state;
  logic [AW-1:0] idx;
  logic [CW-1:0] cnt;
  logic [TW-1:0] timer;
  logic [WIDTH-1:0] m_q;
  logic clr_q;
  logic [DEPTH-1:0][WIDTH-1:0] m_mem;
  logic [DEPTH-1:0][WIDTH-1:0] c_mem;
  logic kill;
  logic tmo;
  logic last;
  always_comb begin
    kill = abort && state != IDLE;
    tmo = state == RUN && !rsa.rsa_eoc && timer == TMAX && !kill;
    last = {1'b0, idx} == cnt - 1'b1;
  end
  // clr_q carries the one-cycle RSA clear that follows an abort or timeout
  assign rsa.rsa_clear = ena && (state == CLEAR || clr_q);
  assign rsa.rsa_en = ena && state == RUN;
  assign rsa.rsa_m = m_q;
  assign busy = state != IDLE;
  assign c_rd_data = c_mem[c_rd_addr];
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      timer <= '0;
      m_q <= '0;
      clr_q <= 1'b0;
      irq <= 1'b0;
      err <= 1'b0;
      m_mem <= '0;
      c_mem <= '0;
    end else if (ena) begin
      clr_q <= 1'b0;
      irq <= (state == DONE && !kill) || (irq && !irq_clr);
      err <= tmo || (err && !irq_clr);
      if (state == IDLE && m_wr_en) m_mem[m_wr_addr] <= m_wr_data;
      if (kill) begin
        state <= IDLE;
        clr_q <= 1'b1;
      end else begin
        case (state)
          IDLE: if (start && !abort) begin
            state <= count == '0 ? DONE : LOAD;
            cnt <= count > CMAX ? CMAX : count;
            idx <= '0;
          end
          LOAD: begin
            m_q <= m_mem[idx];
            state <= CLEAR;
          end
          CLEAR: begin
            timer <= '0;
            state <= RUN;
          end
          RUN: if (rsa.rsa_eoc) begin
            c_mem[idx] <= rsa.rsa_c;
            state <= STORE;
          end else if (tmo) begin
            state <= IDLE;
            clr_q <= 1'b1;
          end else timer <= timer + 1'b1;
          STORE: begin
            state <= last ? DONE : LOAD;
            if (!last) idx <= idx + 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
